// File: rtl/io_map_pkg.sv
// Memory-mapped I/O register offsets shared by the I/O controller and the EX-stage DMEM/IO select.
package io_map_pkg;

  typedef logic [7:0] io_off_t;

  localparam io_off_t IO_UART_CTRL = 8'h00;
  localparam io_off_t IO_UART_RX   = 8'h04;
  localparam io_off_t IO_UART_TX   = 8'h08;
  localparam io_off_t IO_CYC_CNT   = 8'h10;
  localparam io_off_t IO_INST_CNT  = 8'h14;
  localparam io_off_t IO_CNT_RST   = 8'h18;

  // Region match is on the top address nibble only.
  function automatic logic io_in_range(input logic [3:0] addr_hi, input logic [3:0] base_hi);
    return (addr_hi == base_hi);
  endfunction

endpackage

// File: rtl/io_counter.sv
// Wrapping free-running counter with synchronous clear that wins over increment.
module io_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then optional increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO controller: UART byte bridge plus cycle/retired-instruction counters, one-cycle read latency.
module mmio_io_ctrl
  import io_map_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter int          CNT_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  logic             in_range_s;
  io_off_t          off_s;
  logic             rd_s;
  logic             wr_s;
  logic             cnt_clr_s;
  logic [CNT_W-1:0] cyc_cnt_s;
  logic [CNT_W-1:0] inst_cnt_s;
  logic             unused_s;

  logic [31:0] rdata_q,    rdata_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_byte_q,  tx_byte_d;
  logic        rx_full_q,  rx_full_d;
  logic [7:0]  rx_byte_q,  rx_byte_d;

  assign in_range_s = io_in_range(addr[31:28], IO_BASE[31:28]);
  assign off_s      = addr[7:0];
  assign rd_s       = re && in_range_s;
  assign wr_s       = we && in_range_s;
  assign cnt_clr_s  = wr_s && (off_s == IO_CNT_RST);
  assign unused_s   = ^{addr[27:8], wdata[31:8]};

  io_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk (clk),
    .rst (rst),
    .inc (1'b1),
    .clr (cnt_clr_s),
    .q   (cyc_cnt_s)
  );

  io_counter #(.CNT_W(CNT_W)) u_inst (
    .clk (clk),
    .rst (rst),
    .inc (inst_retire),
    .clr (cnt_clr_s),
    .q   (inst_cnt_s)
  );

  // Read mux sampled from pre-edge state; rdata holds when no in-range read.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_s) begin
      case (off_s)
        IO_UART_CTRL: rdata_d = {30'h0, rx_full_q, !tx_valid_q};
        IO_UART_RX:   rdata_d = {24'h0, rx_byte_q};
        IO_CYC_CNT:   rdata_d = 32'(cyc_cnt_s);
        IO_INST_CNT:  rdata_d = 32'(inst_cnt_s);
        default:      rdata_d = 32'h0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // TX slot: handshake frees it, but a store only lands if it was free before the edge.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    if (wr_s && (off_s == IO_UART_TX) && !tx_valid_q) begin
      tx_valid_d = 1'b1;
      tx_byte_d  = wdata[7:0];
    end else if (tx_valid_q && uart_tx_ready) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end
  end

  // RX slot: fill only when empty, pop only when full, so the two are exclusive.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (uart_rx_valid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = uart_rx_data;
    end else if (rd_s && (off_s == IO_UART_RX) && rx_full_q) begin
      rx_full_d = 1'b0;
    end else begin
      rx_full_d = rx_full_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q    <= 32'h0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h0;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= 8'h0;
    end else begin
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  assign rdata         = rdata_q;
  assign uart_tx_valid = tx_valid_q;
  assign uart_tx_data  = tx_byte_q;
  assign uart_rx_ready = !rx_full_q;

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O controller downstream of the EX stage of the three-stage pipeline. Consumes the EX-stage ALU address and store data; produces registered load data for the MWB/writeback mux.
- Bridges CPU loads and stores to a UART ready/valid byte interface.
- Maintains cycle and retired-instruction counters for performance measurement.
- Read data has one-cycle latency, matching the synchronous DMEM timing.

Parameters:
IO_BASE, 32'h8000_0000, base of I/O region; decoded as addr[31:28] == IO_BASE[31:28]
CNT_W, 32, width of cycle and instruction counters (CNT_W <= 32)

Ports:
clk  in  1  pipeline clock
rst  in  1  reset, asynchronous, active-low
addr  in  32  EX-stage ALU result, byte address
wdata  in  32  store data (rs2 value)
we  in  1  store to I/O region this cycle
re  in  1  load from I/O region this cycle
inst_retire  in  1  a non-bubble instruction reaches MWB this cycle
rdata  out  32  registered load data, valid the cycle after re
uart_tx_data  out  8  byte to UART transmitter
uart_tx_valid  out  1  tx byte pending
uart_tx_ready  in  1  transmitter accepts byte
uart_rx_data  in  8  received byte
uart_rx_valid  in  1  receiver has a byte
uart_rx_ready  out  1  controller can accept an rx byte

Behaviour:
- Decode: an access is in range only if addr[31:28] matches IO_BASE. Out-of-range re/we are ignored and rdata holds. Offsets use addr[7:0].
- Offset 0x00, read: {30'b0, rx_full, !tx_valid}. Writes ignored.
- Offset 0x04, read: {24'b0, rx_byte}. If rx_full, the read pops: rx_full clears on the next edge. If empty, returns the stale byte with no state change.
- Offset 0x08, write: if !tx_valid, tx_byte <= wdata[7:0] and tx_valid <= 1. If tx_valid is already 1, the write is dropped and the pending byte is unchanged. Reads return 0.
- Offset 0x10, read: cycle counter. Offset 0x14, read: instruction counter. Both zero-extended to 32 bits.
- Offset 0x18, write (any data): both counters clear. Reads return 0.
- Any other in-range offset: reads return 0, writes ignored.
- rdata: captured on the clock edge ending the re cycle. Holds until the next in-range re.
- Counter reads return the value before that cycle's increment or clear.
- TX handshake:
  - uart_tx_valid = tx_valid; uart_tx_data = tx_byte.
  - When tx_valid && uart_tx_ready at an edge, tx_valid <= 0.
  - A new write accepted in the handshake cycle is still dropped, because acceptance is decided on pre-edge tx_valid.
- RX handshake:
  - uart_rx_ready = !rx_full.
  - When uart_rx_valid && !rx_full at an edge: rx_byte <= uart_rx_data, rx_full <= 1.
  - Fill happens only when empty and pop only when full, so they never coincide.
- Cycle counter: +1 every cycle out of reset, wraps at 2^CNT_W.
- Instruction counter: +1 on cycles with inst_retire, wraps at 2^CNT_W.
- The 0x18 clear has priority over increment: the counter is 0 after the edge, not 1.
- we and re both asserted: write performed; read also performed with pre-edge state.
- Reset (rst low, asynchronous): rdata = 0, both counters = 0, tx_valid = 0, tx_byte = 0, rx_full = 0, rx_byte = 0. Hence uart_rx_ready = 1 and uart_tx_valid = 0.
- Reset mid-handshake drops any pending tx/rx byte. Counting resumes on the first edge after rst deasserts.

Decomposition:
- Shared package io_map_pkg: offsets IO_UART_CTRL = 8'h00, IO_UART_RX = 8'h04, IO_UART_TX = 8'h08, IO_CYC_CNT = 8'h10, IO_INST_CNT = 8'h14, IO_CNT_RST = 8'h18. The EX-stage DMEM/IO select logic uses the same constants.
- One sub-module, io_counter (CNT_W, inc, clr, async active-low rst, q), instantiated twice.

Test Plan:
- Release rst, idle 10 cycles, read 0x8000_0010 -> rdata = 10 one cycle after re (±0 by exact edge count); read 0x8000_0000 -> 32'h1.
- Store 0x41 to 0x8000_0008 with uart_tx_ready = 0 -> uart_tx_valid = 1, uart_tx_data = 8'h41. Store 0x42 while pending -> data stays 8'h41. Raise uart_tx_ready for one cycle -> uart_tx_valid = 0 next cycle.
- Drive uart_rx_valid with 8'h5A -> uart_rx_ready falls, ctrl read = 32'h3. Read 0x8000_0004 -> rdata = 32'h5A, then uart_rx_ready = 1. Second read -> 32'h5A with ready unchanged.
- Pulse inst_retire on 7 of 12 cycles, read 0x8000_0014 -> 7. Write 0x8000_0018 in a cycle with inst_retire = 1 -> both counters 0 after the edge.
- Preload cycle counter near 32'hFFFF_FFFF (force), run 2 cycles -> wraps to 1. Read 0x8000_001C -> 0. Read 0x9000_0010 -> rdata unchanged.
- Assert rst low mid-operation with tx_valid = 1 and rx_full = 1 -> immediately uart_tx_valid = 0, uart_rx_ready = 1, rdata = 0.
